// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared frame-parser state encoding and loader defaults
package ram_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK} state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int ADDR_W_DEF = 13;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte gap counter that flags expiry after TIMEOUT_CYCLES idle cycles
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en) ? '0 : cnt + 1'b1;
  // a byte arriving on the expiry cycle wins, so clr masks the flag
  assign expired = en && !clr && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ram_loader.sv
// ram_loader: parses framed UART bytes into RAM writes and muxes the RAM port with the CPU
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_w_en,
  input  logic [7:0]        cpu_din,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_w_en,
  output logic [7:0]        ram_din,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state, state_n;
  logic [7:0] addr_hi, acc, ld_din;
  logic [15:0] len;
  logic [ADDR_W-1:0] ptr, ld_addr;
  logic ld_w_en, done_n, error_n, expired, wr;
  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(rx_valid), .en(state != S_IDLE), .expired(expired)
  );
  assign wr = rx_valid && state == S_DATA;
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    error_n = 1'b0;
    if (rx_valid)
      case (state)
        S_IDLE:    state_n = (rx_data == SYNC_BYTE) ? S_ADDR_HI : S_IDLE;
        S_ADDR_HI: state_n = S_ADDR_LO;
        S_ADDR_LO: state_n = S_LEN_HI;
        S_LEN_HI:  state_n = S_LEN_LO;
        S_LEN_LO:  state_n = ({len[15:8], rx_data} == 16'd0) ? S_CHECK : S_DATA;
        S_DATA:    state_n = (len == 16'd1) ? S_CHECK : S_DATA;
        S_CHECK: begin
          state_n = S_IDLE;
          done_n = rx_data == acc;
          error_n = rx_data != acc;
        end
        default:   state_n = S_IDLE;
      endcase
    else if (expired) begin
      state_n = S_IDLE;
      error_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      addr_hi <= '0;
      ptr <= '0;
      len <= '0;
      acc <= '0;
      ld_w_en <= 1'b0;
      ld_addr <= '0;
      ld_din <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      done <= done_n;
      error <= error_n;
      ld_w_en <= wr;
      if (rx_valid && state == S_ADDR_HI) addr_hi <= rx_data;
      if (rx_valid && state == S_ADDR_LO) ptr <= ADDR_W'({addr_hi, rx_data});
      if (rx_valid && state == S_LEN_HI) len[15:8] <= rx_data;
      if (rx_valid && state == S_LEN_LO) len[7:0] <= rx_data;
      if (wr) begin
        ld_addr <= ptr;
        ld_din <= rx_data;
        ptr <= ptr + 1'b1;
        len <= len - 1'b1;
      end
      acc <= (state_n == S_IDLE) ? '0 : wr ? acc ^ rx_data : acc;
    end
  assign busy = state != S_IDLE || ld_w_en;
  assign ram_address = busy ? ld_addr : cpu_address;
  assign ram_w_en = busy ? ld_w_en : cpu_w_en;
  assign ram_din = busy ? ld_din : cpu_din;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized and directed frame checks of ram_loader against a frame-level model
module tb_ram_loader;
  localparam int AW = 13;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, cpu_w_en = 1'b0;
  logic [7:0] rx_data = '0, cpu_din = '0, ram_din;
  logic [AW-1:0] cpu_address = '0, ram_address;
  logic ram_w_en, busy, done, error;
  int n_chk = 0, n_fail = 0, n_done = 0, n_err = 0, n_both = 0;
  logic [AW-1:0] obs_a[$], exp_a[$];
  logic [7:0] obs_d[$], exp_d[$], fr[$], dat[$];
  bit exp_ok;
  always #5 clk = ~clk;
  ram_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_address(cpu_address), .cpu_w_en(cpu_w_en), .cpu_din(cpu_din),
    .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_din(ram_din),
    .busy(busy), .done(done), .error(error)
  );
  // what the RAM sees each cycle, plus pulse counts
  always @(negedge clk) begin
    if (ram_w_en === 1'b1) begin
      obs_a.push_back(ram_address);
      obs_d.push_back(ram_din);
    end
    if (done === 1'b1) n_done++;
    if (error === 1'b1) n_err++;
    if (done === 1'b1 && error === 1'b1) n_both++;
  end
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic clear_log;
    obs_a.delete();
    obs_d.delete();
    n_done = 0;
    n_err = 0;
    n_both = 0;
  endtask
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      step;
      rx_valid = 1'b1;
      rx_data = fr[i];
      if (gaps && i < fr.size() - 1)
        repeat ($urandom_range(0, 2)) begin
          step;
          rx_valid = 1'b0;
        end
    end
    step;
    rx_valid = 1'b0;
  endtask
  task automatic make_frame(input logic [15:0] a, input bit good);
    logic [7:0] x;
    x = 8'h00;
    fr.delete();
    exp_a.delete();
    exp_d.delete();
    fr.push_back(8'hA5);
    fr.push_back(a[15:8]);
    fr.push_back(a[7:0]);
    fr.push_back(8'(dat.size() >> 8));
    fr.push_back(8'(dat.size()));
    foreach (dat[i]) begin
      fr.push_back(dat[i]);
      exp_a.push_back(AW'((int'(a) + i) % (1 << AW)));
      exp_d.push_back(dat[i]);
      x ^= dat[i];
    end
    fr.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
    exp_ok = good;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    cpu_address = 13'h0155;
    cpu_din = 8'h3C;
    cpu_w_en = 1'b1;
    #2;
    n_chk++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/error=%b want 000", {busy, done, error}); end
    n_chk++; if (ram_w_en !== 1'b1 || ram_address !== 13'h0155 || ram_din !== 8'h3C) begin n_fail++; $display("FAIL reset_passthru: w=%b a=%h d=%h want 1 0155 3c", ram_w_en, ram_address, ram_din); end
    cpu_w_en = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    step;
  endtask
  task automatic test_frames;
    for (int s = 0; s < 20; s++) begin
      dat.delete();
      case (s)
        0, 1: begin
          dat = {8'h11, 8'h22, 8'h33};
          make_frame(16'h0200, s == 0);
          if (s == 1) fr[fr.size() - 1] = 8'h01;
        end
        2: begin
          dat = {8'hAA, 8'hBB};
          make_frame(16'h1FFF, 1'b1);
        end
        3: make_frame(16'h0010, 1'b1);
        default: begin
          repeat ($urandom_range(0, 6)) dat.push_back(8'($urandom));
          make_frame(16'($urandom), $urandom_range(0, 3) != 0);
        end
      endcase
      clear_log;
      send_frame(s[0]);
      n_chk++; if ({done, error} !== {exp_ok, !exp_ok}) begin n_fail++; $display("FAIL frame%0d_pulse: done/error=%b%b want %b%b", s, done, error, exp_ok, !exp_ok); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame%0d_busy: busy=%b want 0", s, busy); end
      step;
      n_chk++; if (n_done !== int'(exp_ok) || n_err !== int'(!exp_ok) || n_both !== 0) begin n_fail++; $display("FAIL frame%0d_counts: done=%0d error=%0d both=%0d want %0d %0d 0", s, n_done, n_err, n_both, exp_ok, !exp_ok); end
      n_chk++;
      if (obs_a.size() !== exp_a.size()) begin n_fail++; $display("FAIL frame%0d_nwrites: got %0d want %0d", s, obs_a.size(), exp_a.size()); end
      else foreach (exp_a[i]) begin
        n_chk++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL frame%0d_write%0d: got %h=%h want %h=%h", s, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]); end
      end
    end
  endtask
  task automatic test_timeout;
    int k;
    logic [7:0] f2[$];
    clear_log;
    fr = {8'h41, 8'h42, 8'hA5, 8'h00, 8'h10};
    send_frame(1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before: busy=%b want 1", busy); end
    k = 0;
    while (k < 300 && error !== 1'b1) begin
      step;
      k++;
    end
    n_chk++; if (k !== 100) begin n_fail++; $display("FAIL timeout_latency: error after %0d cycles want 100", k); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: busy=%b want 0", busy); end
    step;
    n_chk++; if (n_err !== 1 || n_done !== 0 || obs_a.size() !== 0) begin n_fail++; $display("FAIL timeout_effects: error=%0d done=%0d writes=%0d want 1 0 0", n_err, n_done, obs_a.size()); end
    dat = {8'h5A, 8'hC3};
    make_frame(16'h0123, 1'b1);
    f2 = fr;
    clear_log;
    foreach (f2[i]) begin
      fr = {f2[i]};
      send_frame(1'b0);
      if (i < f2.size() - 1) repeat (90) step;
    end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL slow_frame_done: done=%b want 1", done); end
    step;
    n_chk++; if (n_err !== 0 || obs_a.size() !== 2) begin n_fail++; $display("FAIL slow_frame_effects: error=%0d writes=%0d want 0 2", n_err, obs_a.size()); end
  endtask
  task automatic test_cpu_mux;
    cpu_address = 13'h0300;
    cpu_din = 8'h5A;
    cpu_w_en = 1'b1;
    #1;
    n_chk++; if (ram_w_en !== 1'b1 || ram_address !== 13'h0300 || ram_din !== 8'h5A) begin n_fail++; $display("FAIL cpu_idle_passthru: w=%b a=%h d=%h want 1 0300 5a", ram_w_en, ram_address, ram_din); end
    cpu_w_en = 1'b0;
    step;
    clear_log;
    fr = {8'hA5};
    send_frame(1'b0);
    cpu_w_en = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b1 || ram_w_en !== 1'b0) begin n_fail++; $display("FAIL cpu_blocked: busy=%b w=%b want 1 0", busy, ram_w_en); end
    fr = {8'h00, 8'h40, 8'h00, 8'h02, 8'hC3, 8'h3C};
    send_frame(1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cpu_busy_frame: busy=%b want 1", busy); end
    cpu_w_en = 1'b0;
    fr = {8'hFF};
    send_frame(1'b0);
    step;
    n_chk++; if (n_done !== 1 || obs_a.size() !== 2) begin n_fail++; $display("FAIL cpu_frame_counts: done=%0d writes=%0d want 1 2", n_done, obs_a.size()); end
    else begin
      n_chk++; if (obs_a[0] !== 13'h0040 || obs_d[0] !== 8'hC3 || obs_a[1] !== 13'h0041 || obs_d[1] !== 8'h3C) begin n_fail++; $display("FAIL cpu_frame_writes: got %h=%h %h=%h want 0040=c3 0041=3c", obs_a[0], obs_d[0], obs_a[1], obs_d[1]); end
    end
  endtask
  task automatic test_reset_mid_frame;
    clear_log;
    fr = {8'hA5, 8'h04, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
    send_frame(1'b0);
    n_chk++; if (obs_a.size() !== 2) begin n_fail++; $display("FAIL midrst_prewrites: got %0d want 2", obs_a.size()); end
    cpu_address = 13'h00AB;
    cpu_w_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({ram_w_en, busy, done, error} !== 4'b0000 || ram_address !== 13'h00AB) begin n_fail++; $display("FAIL midrst_outputs: w/busy/done/error=%b a=%h want 0000 00ab", {ram_w_en, busy, done, error}, ram_address); end
    clear_log;
    repeat (2) step;
    rst_n = 1'b1;
    fr = {8'h03, 8'h04, 8'h04};
    send_frame(1'b0);
    repeat (3) step;
    n_chk++; if (obs_a.size() !== 0 || n_done !== 0 || n_err !== 0) begin n_fail++; $display("FAIL midrst_after: writes=%0d done=%0d error=%0d want 0 0 0", obs_a.size(), n_done, n_err); end
    dat = {8'h01, 8'h02, 8'h03, 8'h04};
    make_frame(16'h0400, 1'b1);
    clear_log;
    send_frame(1'b1);
    step;
    n_chk++; if (n_done !== 1 || obs_a.size() !== 4) begin n_fail++; $display("FAIL midrst_reload: done=%0d writes=%0d want 1 4", n_done, obs_a.size()); end
    else foreach (exp_a[i]) begin
      n_chk++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL midrst_reload_write%0d: got %h=%h want %h=%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_frames;
    test_timeout;
    test_cpu_mux;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
